// File: rtl/load_store_unit.sv
// load_store_unit: one-outstanding-request load/store unit between the execute
// stage and a valid/ready data bus. Stores finish on the address/data
// handshake. Loads wait for the read return, align and extend the data, and
// write it straight into the register file RD port. Misaligned or illegal
// requests are rejected without touching the bus.
module load_store_unit #(
  parameter int XLEN    = 32,
  parameter int REGID_W = 5
) (
  input  logic               clk,
  input  logic               rst_b,
  // execute-stage request
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_write,
  input  logic [1:0]         req_size,
  input  logic               req_unsigned,
  input  logic [XLEN-1:0]    req_addr,
  input  logic [XLEN-1:0]    req_wdata,
  input  logic [REGID_W-1:0] req_rd,
  // data bus
  output logic               bus_valid,
  input  logic               bus_ready,
  output logic               bus_write,
  output logic [XLEN-1:0]    bus_addr,
  output logic [XLEN-1:0]    bus_wdata,
  output logic [3:0]         bus_wstrb,
  input  logic               bus_rvalid,
  input  logic [XLEN-1:0]    bus_rdata,
  // register file RD write port and status
  output logic [REGID_W-1:0] rd_addr,
  output logic [XLEN-1:0]    rd_wdata,
  output logic               rd_write,
  output logic               lsu_done,
  output logic               lsu_misalign
);

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_RESP,
    S_WB,
    S_DONE,
    S_ERR
  } state_t;

  state_t r_state;

  // Fields latched at acceptance and needed later to format the load return.
  logic [1:0]         r_size;
  logic               r_unsigned;
  logic [1:0]         r_lane;
  logic [REGID_W-1:0] r_rd;

  // Registered outputs.
  logic               r_bus_valid;
  logic               r_bus_write;
  logic [XLEN-1:0]    r_bus_addr;
  logic [XLEN-1:0]    r_bus_wdata;
  logic [3:0]         r_bus_wstrb;
  logic [REGID_W-1:0] r_rd_addr;
  logic [XLEN-1:0]    r_rd_wdata;
  logic               r_rd_write;
  logic               r_done;
  logic               r_misalign;

  // Request decode and formatting, computed from the live request in IDLE.
  logic               w_misalign;
  logic [3:0]         w_store_wstrb;
  logic [XLEN-1:0]    w_store_wdata;

  // Load return path, computed from the live bus data and latched fields.
  logic [XLEN-1:0]    w_shifted;
  logic               w_ext_bit;
  logic [XLEN-1:0]    w_load_data;

  // Accept only in IDLE; req_valid in any other state is ignored.
  assign req_ready = (r_state == S_IDLE);

  // Misaligned: odd half, word not on a 4-byte boundary, or the illegal size.
  assign w_misalign = (req_size == 2'd3)
                    | ((req_size == SIZE_HALF) & req_addr[0])
                    | ((req_size == SIZE_WORD) & (req_addr[1:0] != 2'b00));

  // Store lane enables and lane-replicated write data.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    w_store_wstrb = 4'b1111;
    w_store_wdata = req_wdata;
    case (req_size)
      SIZE_BYTE: begin
        w_store_wstrb = 4'b0001 << req_addr[1:0];
        w_store_wdata = {4{req_wdata[7:0]}};
      end
      SIZE_HALF: begin
        w_store_wstrb = 4'b0011 << req_addr[1:0];
        w_store_wdata = {2{req_wdata[15:0]}};
      end
      default: begin
        w_store_wstrb = 4'b1111;
        w_store_wdata = req_wdata;
      end
    endcase
  end

  // Bring the addressed bytes down to bit 0 of the returned word.
  assign w_shifted = bus_rdata >> {r_lane, 3'b000};

  // Load data: select byte/half/word and zero- or sign-extend it.
  always_comb begin
    w_ext_bit   = 1'b0;
    w_load_data = w_shifted;
    case (r_size)
      SIZE_BYTE: begin
        w_ext_bit   = r_unsigned ? 1'b0 : w_shifted[7];
        w_load_data = {{(XLEN-8){w_ext_bit}}, w_shifted[7:0]};
      end
      SIZE_HALF: begin
        w_ext_bit   = r_unsigned ? 1'b0 : w_shifted[15];
        w_load_data = {{(XLEN-16){w_ext_bit}}, w_shifted[15:0]};
      end
      default: begin
        w_ext_bit   = 1'b0;
        w_load_data = w_shifted;
      end
    endcase
  end

  // Control FSM with all outputs registered; pulses default low each cycle.
  always_ff @(posedge clk or negedge rst_b) begin
    // NOTE: reset clears every state and output register so that a reset in
    // the middle of an operation abandons the bus transaction outright.
    if (!rst_b) begin
      r_state     <= S_IDLE;
      r_size      <= SIZE_BYTE;
      r_unsigned  <= 1'b0;
      r_lane      <= 2'b00;
      r_rd        <= '0;
      r_bus_valid <= 1'b0;
      r_bus_write <= 1'b0;
      r_bus_addr  <= '0;
      r_bus_wdata <= '0;
      r_bus_wstrb <= 4'b0000;
      r_rd_addr   <= '0;
      r_rd_wdata  <= '0;
      r_rd_write  <= 1'b0;
      r_done      <= 1'b0;
      r_misalign  <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments only, so every
      // register here sees the values from before this clock edge.
      r_rd_write <= 1'b0;
      r_done     <= 1'b0;
      r_misalign <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_size     <= req_size;
            r_unsigned <= req_unsigned;
            r_lane     <= req_addr[1:0];
            r_rd       <= req_rd;
            if (w_misalign) begin
              r_state    <= S_ERR;
              r_misalign <= 1'b1;
              r_done     <= 1'b1;
            end else begin
              r_state     <= S_REQ;
              r_bus_valid <= 1'b1;
              r_bus_write <= req_write;
              r_bus_addr  <= {req_addr[XLEN-1:2], 2'b00};
              r_bus_wdata <= w_store_wdata;
              r_bus_wstrb <= req_write ? w_store_wstrb : 4'b0000;
            end
          end
        end

        S_REQ: begin
          if (bus_ready) begin
            r_bus_valid <= 1'b0;
            if (r_bus_write) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= S_RESP;
            end
          end
        end

        S_RESP: begin
          if (bus_rvalid) begin
            r_state    <= S_WB;
            r_rd_addr  <= r_rd;
            r_rd_wdata <= w_load_data;
            r_rd_write <= (r_rd != '0);
            r_done     <= 1'b1;
          end
        end

        S_WB, S_DONE, S_ERR: r_state <= S_IDLE;

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus_valid    = r_bus_valid;
  assign bus_write    = r_bus_write;
  assign bus_addr     = r_bus_addr;
  assign bus_wdata    = r_bus_wdata;
  assign bus_wstrb    = r_bus_wstrb;
  assign rd_addr      = r_rd_addr;
  assign rd_wdata     = r_rd_wdata;
  assign rd_write     = r_rd_write;
  assign lsu_done     = r_done;
  assign lsu_misalign = r_misalign;

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Load/store unit for the single-cycle core. It accepts one memory request at a time from the execute stage and runs it on a valid/ready data bus. For loads, it aligns and extends the returned data and drives the register file RD write port directly. Stores complete on the bus address/data handshake and produce no register write.

## Interface
- XLEN, 32, data/address width; only 32 is supported (4 byte lanes).
- REGID_W, 5, register ID width; must match the register file.

Ports:
- clk  in  1  clock; all state changes on its rising edge
- rst_b  in  1  asynchronous active-low reset
- req_valid  in  1  execute stage presents a memory op
- req_ready  out  1  unit can accept a request
- req_write  in  1  1 = store, 0 = load
- req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = illegal
- req_unsigned  in  1  loads only: zero-extend instead of sign-extend
- req_addr  in  XLEN  byte address
- req_wdata  in  XLEN  store data, right-aligned
- req_rd  in  REGID_W  load destination register
- bus_valid  out  1  bus request valid
- bus_ready  in  1  bus accepts the request
- bus_write  out  1  bus request is a store
- bus_addr  out  XLEN  word-aligned address {req_addr[31:2], 2'b00}
- bus_wdata  out  XLEN  lane-replicated store data
- bus_wstrb  out  4  byte-lane write enables (0 for loads)
- bus_rvalid  in  1  load data return
- bus_rdata  in  XLEN  load data word
- rd_addr  out  REGID_W  RD write address
- rd_wdata  out  XLEN  RD write data
- rd_write  out  1  one-cycle RD write strobe
- lsu_done  out  1  one-cycle pulse: op completed (load, store or error)
- lsu_misalign  out  1  one-cycle pulse: misaligned or illegal request, no bus access

## Operation
- FSM states:
  - IDLE
    - req_ready = 1.
    - On req_valid, latch all req_* fields.
    - Misaligned request goes to ERR; otherwise go to REQ.
  - REQ
    - bus_valid = 1; bus_* outputs hold latched values until bus_ready.
    - On bus_ready: a store goes to DONE; a load goes to RESP.
  - RESP
    - Waits for bus_rvalid.
    - On bus_rvalid, capture the formatted data and go to WB.
  - WB
    - rd_write = 1 unless the latched rd = 0.
    - lsu_done = 1; go to IDLE.
  - DONE
    - lsu_done = 1; go to IDLE.
  - ERR
    - lsu_misalign = 1 and lsu_done = 1; go to IDLE. No bus activity.
- Misaligned means any of: half with addr[0] = 1; word with addr[1:0] ≠ 0; size = 3.
- Store formatting:
  - Byte: wstrb = 4'b0001 << addr[1:0], wdata = {4{wdata[7:0]}}.
  - Half: wstrb = 4'b0011 << addr[1:0], wdata = {2{wdata[15:0]}}.
  - Word: wstrb = 4'b1111, wdata unchanged.
- Load formatting:
  - Shift: tmp = bus_rdata >> (8 × addr[1:0]).
  - Byte: tmp[7:0], extended from bit 7.
  - Half: tmp[15:0], extended from bit 15.
  - Word: tmp unchanged.
  - Extension is zero-extend if req_unsigned, otherwise sign-extend.
- bus_rvalid is ignored in every state except RESP.
- req_valid is ignored outside IDLE.

## Timing
- Reset (asynchronous, rst_b low):
  - State goes to IDLE.
  - bus_valid, bus_write, bus_wstrb, bus_addr, bus_wdata, rd_write, rd_addr, rd_wdata, lsu_done, lsu_misalign are all 0.
  - req_ready is 1 once reset is released.
  - Reset mid-operation abandons the bus transaction.
  - A stray rvalid arriving after reset is ignored (state is IDLE).
- Request accepted at cycle T (req_valid & req_ready): bus_valid is registered high at T+1.
- Load, zero wait states:
  - bus_ready at T+1, bus_rvalid at T+2.
  - rd_write and lsu_done at T+3.
  - Throughput is one load per 4 cycles.
- Store, zero wait states: bus_ready at T+1, lsu_done at T+2.
- Misaligned request: lsu_misalign and lsu_done at T+1.
- Each cycle of bus_ready low extends REQ by one cycle; each cycle of rvalid low extends RESP by one cycle.
- rd_addr/rd_wdata are registered; they are valid when rd_write = 1 and hold their value otherwise.

## Test plan
- Word load from 0x100, bus_rdata = 0xDEADBEEF, rd = 5, zero wait states → bus_addr 0x100, wstrb 0; rd_write at T+3 with rd_addr 5, rd_wdata 0xDEADBEEF.
- Signed byte load from 0x203, rdata = 0x80112233 → rd_wdata 0xFFFFFF80. Same request with unsigned → 0x00000080.
- Half store to 0x302, wdata = 0x0000ABCD → bus_addr 0x300, wstrb 4'b1100, bus_wdata 0xABCDABCD, lsu_done at T+2, no rd_write.
- Word load from 0x1002 → lsu_misalign and lsu_done at T+1, bus_valid never asserted, req_ready back high at T+2.
- Store with bus_ready held low 3 cycles → bus_valid and all bus_* stable for 4 cycles; lsu_done the cycle after the handshake.
- Load with rd = 0 → lsu_done pulses, rd_write stays 0.
- rst_b low during RESP, then rvalid arrives → all outputs 0 immediately, rvalid ignored, no rd_write.
